// File: rtl/imem_boot_loader_if.sv
// Valid/ready program-word stream feeding the instruction-memory boot loader.
interface imem_boot_loader_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/imem_boot_loader.sv
// Boot engine: streams program words into instruction memory and holds the CPU in reset until loaded.
// Optional running-sum check of the loaded image: define IMEM_BOOT_LOADER_CHECKSUM_EN.
module imem_boot_loader #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 512
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic [ADDR_W:0]     num_words_i,
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    input  logic [DATA_W-1:0]   expected_sum_i,
`endif
    imem_boot_loader_if.slave   in_if,
    output logic                im_en_o,
    output logic [ADDR_W-1:0]   im_addr_o,
    output logic [DATA_W-1:0]   im_wdata_o,
    output logic                cpu_rst_n_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                error_o,
    output logic [ADDR_W:0]     words_loaded_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        RUN   = 3'd3,
        ERR   = 3'd4
    } state_e;

    localparam logic [ADDR_W+1:0] MAX_W  = (ADDR_W+2)'(MAX_WORDS);
    localparam logic [ADDR_W+1:0] MEM_W  = (ADDR_W+2)'(2**ADDR_W);
    localparam logic [ADDR_W+1:0] BASE_W = (ADDR_W+2)'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);

    state_e              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                im_en_q, im_en_d;
    logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
    logic [DATA_W-1:0]   im_wdata_q, im_wdata_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [ADDR_W:0]     words_loaded_q, words_loaded_d;
    logic [ADDR_W:0]     num_words_q, num_words_d;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]   sum_q, sum_d;
    logic [DATA_W-1:0]   exp_q, exp_d;
`endif

    logic [ADDR_W+1:0]   nwExt;
    logic                lengthOk;
    logic                accept;
    logic [ADDR_W:0]     wordsNext;

    // Range check is done in ADDR_W+2 bits so the end address can never wrap.
    assign nwExt     = {1'b0, num_words_i};
    assign lengthOk  = (nwExt != '0) && (nwExt <= MAX_W) && ((BASE_W + nwExt) <= MEM_W);
    assign accept    = (state_q == LOAD) && in_ready_q && in_if.in_valid;
    assign wordsNext = words_loaded_q + (ADDR_W+1)'(1);

    always_comb begin
        state_d        = state_q;
        in_ready_d     = 1'b0;
        im_en_d        = 1'b0;
        im_addr_d      = im_addr_q;
        im_wdata_d     = im_wdata_q;
        words_loaded_d = words_loaded_q;
        num_words_d    = num_words_q;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
        sum_d          = sum_q;
        exp_d          = exp_q;
`endif
        case (state_q)
            IDLE, RUN, ERR: begin
                if (start_i) begin
                    if (lengthOk) begin
                        state_d        = LOAD;
                        in_ready_d     = 1'b1;
                        words_loaded_d = '0;
                        num_words_d    = num_words_i;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                        sum_d          = '0;
                        exp_d          = expected_sum_i;
`endif
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            LOAD: begin
                in_ready_d = in_ready_q;
                if (accept) begin
                    im_en_d        = 1'b1;
                    im_addr_d      = BASE_A + words_loaded_q[ADDR_W-1:0];
                    im_wdata_d     = in_if.in_data;
                    words_loaded_d = wordsNext;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                    sum_d          = sum_q + in_if.in_data;
`endif
                    if (wordsNext == num_words_q) begin
                        in_ready_d = 1'b0;
                        state_d    = DRAIN;
                    end
                end
            end
            DRAIN: begin
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
                state_d = (sum_q == exp_q) ? RUN : ERR;
`else
                state_d = RUN;
`endif
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are derived from the next state so they stay registered.
        cpu_rst_n_d = (state_d == RUN);
        busy_d      = (state_d == LOAD) || (state_d == DRAIN);
        done_d      = (state_q == DRAIN) && (state_d == RUN);
        error_d     = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            in_ready_q     <= 1'b0;
            im_en_q        <= 1'b0;
            im_addr_q      <= '0;
            im_wdata_q     <= '0;
            cpu_rst_n_q    <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            words_loaded_q <= '0;
            num_words_q    <= '0;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            sum_q          <= '0;
            exp_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            in_ready_q     <= in_ready_d;
            im_en_q        <= im_en_d;
            im_addr_q      <= im_addr_d;
            im_wdata_q     <= im_wdata_d;
            cpu_rst_n_q    <= cpu_rst_n_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
            words_loaded_q <= words_loaded_d;
            num_words_q    <= num_words_d;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
            sum_q          <= sum_d;
            exp_q          <= exp_d;
`endif
        end
    end

    assign in_if.in_ready = in_ready_q;
    assign im_en_o        = im_en_q;
    assign im_addr_o      = im_addr_q;
    assign im_wdata_o     = im_wdata_q;
    assign cpu_rst_n_o    = cpu_rst_n_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign words_loaded_o = words_loaded_q;

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Parametrised boot engine that streams program words over a valid/ready input and writes them into the CPU instruction memory through its write port (im_en / address / data).
- Holds the CPU in reset while loading and releases it once the last word is written.
- Replaces manual poking of the instruction-memory write port with a single reusable, width/depth-generic block usable in both system and bench.

Parameters:
DATA_W, 32, instruction word width in bits
ADDR_W, 9, instruction memory word-address width
BASE_ADDR, 0, first word address written
MAX_WORDS, 512, largest legal program length in words

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  begin a (re)load; sampled only in IDLE, RUN, ERR
num_words  input  ADDR_W+1  program length in words; sampled with start
in_valid  input  1  input word valid
in_data  input  DATA_W  input program word
in_ready  output  1  loader accepts in_data this cycle
im_en  output  1  instruction memory write enable
im_addr  output  ADDR_W  instruction memory write word address
im_wdata  output  DATA_W  instruction memory write data
cpu_rst_n  output  1  active-low reset to the CPU
busy  output  1  high in LOAD and DRAIN
done  output  1  one-cycle pulse when the CPU is released
error  output  1  sticky error flag
words_loaded  output  ADDR_W+1  count of words accepted in the current load

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, in_ready=0, im_en=0, im_addr=0, im_wdata=0, cpu_rst_n=0, busy=0, done=0, error=0, words_loaded=0. Reset mid-load aborts the load; memory already written is not cleared.
- All outputs are registered. The FSM has 5 states: IDLE, LOAD, DRAIN, RUN, ERR.
- IDLE, on start:
  - If num_words==0, num_words>MAX_WORDS, or BASE_ADDR+num_words>2**ADDR_W: go to ERR.
  - Otherwise go to LOAD, clear words_loaded, set in_ready=1.
- LOAD:
  - A beat is accepted when in_valid && in_ready at an edge.
  - At that same edge: im_en=1, im_addr=BASE_ADDR+words_loaded, im_wdata=in_data, words_loaded++. Write latency is 1 cycle from acceptance.
  - On a cycle with no accepted beat, im_en=0 at the next edge.
  - in_valid may drop at any time; there is no timeout.
  - When the accepted beat makes words_loaded==num_words: in_ready=0 at that edge, then go to DRAIN. No further beat is accepted.
- DRAIN (1 cycle): im_en=0, then go to RUN with cpu_rst_n=1 and done=1 for exactly one cycle.
- RUN: cpu_rst_n=1, in_ready=0, busy=0.
  - start reloads: cpu_rst_n=0 at the same edge, then the same length checks and LOAD entry as IDLE.
- ERR: error=1, cpu_rst_n=0, in_ready=0.
  - start clears error at the same edge and is evaluated exactly as in IDLE (it may return to ERR).
- start is ignored in LOAD and DRAIN. start coincident with rst_n=0: reset wins.
- cpu_rst_n is 0 in every state except RUN. busy = (state==LOAD || state==DRAIN).
- Address arithmetic is ADDR_W bits. The start-time range check guarantees no wrap-around.

Optional Feature:
- Macro: IMEM_BOOT_LOADER_CHECKSUM_EN.
- When defined:
  - Adds input expected_sum [DATA_W-1:0], sampled with start.
  - A running sum (mod 2**DATA_W) of accepted words is cleared on LOAD entry.
  - In DRAIN, the sum is compared with expected_sum. Match: RUN/done as normal. Mismatch: go to ERR, no done pulse, cpu_rst_n stays 0.
- When undefined: no expected_sum port, no adder; DRAIN always goes to RUN.

Test Plan:
- Reset, then start with num_words=2; drive 0x02268193 and 0x00000013 back-to-back -> im_en high two cycles at addr 0,1 with those data; in_ready low after the 2nd beat; done pulses 2 cycles after the last accept; cpu_rst_n=1; words_loaded=2.
- Same load with in_valid gapped (1 idle cycle between beats) -> im_en only on accept cycles, addresses still 0,1, no extra writes.
- start with num_words=0, then separately num_words=MAX_WORDS+1 -> error=1, cpu_rst_n=0, no im_en. A following valid start with num_words=1 clears error and completes.
- In RUN, assert start with num_words=1 and data 0xDEADBEEF -> cpu_rst_n=0 next cycle, write at addr 0, done, cpu_rst_n=1 again.
- Deassert rst_n after 1 of 3 words -> all outputs at reset values next cycle; state IDLE; extra in_valid ignored.
- With IMEM_BOOT_LOADER_CHECKSUM_EN: words 0x1, 0x2 with expected_sum=0x3 -> RUN. Repeat with expected_sum=0x4 -> ERR, no done pulse.
